// File: rtl/channel_reduce_arbiter_if.sv
// Bundle of the NCH producer read channels and the single result write channel
// shared by the reduction scheduler.
interface channel_reduce_arbiter_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NCH   = 4
);
    localparam int unsigned TW = $clog2(NCH);

    logic [NCH*WIDTH-1:0] in_out_data;
    logic [NCH-1:0]       in_read_ready;
    logic [NCH-1:0]       in_read_valid;
    logic [NCH-1:0]       in_rst;
    logic [WIDTH-1:0]     out_in_data;
    logic [TW-1:0]        out_tag;
    logic                 out_write_valid;
    logic                 out_rst;
    logic                 out_write_ready;
    logic                 busy;
    logic [TW-1:0]        grant;

    modport master (
        input  in_out_data, in_read_ready, out_write_ready,
        output in_read_valid, in_rst, out_in_data, out_tag, out_write_valid,
        output out_rst, busy, grant
    );

    modport slave (
        output in_out_data, in_read_ready, out_write_ready,
        input  in_read_valid, in_rst, out_in_data, out_tag, out_write_valid,
        input  out_rst, busy, grant
    );
endinterface

// File: rtl/channel_reduce_arbiter.sv
// Round-robin reduction scheduler: reads LEN words from the granted channel,
// sums them modulo 2^WIDTH and writes the tagged sum to one output channel.
module channel_reduce_arbiter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NCH   = 4,
    parameter int unsigned LEN   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    channel_reduce_arbiter_if.master bus
);
    localparam int unsigned TW = $clog2(NCH);
    localparam int unsigned CW = (LEN > 1) ? $clog2(LEN) : 1;

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_CAP, WR_WAIT, WR} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [TW-1:0]    grant_q, grant_d;
    logic [TW-1:0]    last_q, last_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [TW-1:0]    tag_q, tag_d;
    logic             wv_q, wv_d;
    logic             busy_q;

    logic [TW-1:0]    pick;
    logic             any_ready;
    logic [TW:0]      idx;
    logic [WIDTH-1:0] rd_word;
    logic [NCH-1:0]   rv_c;

    // Next grant: first ready channel at offset 1..NCH after last; the
    // descending scan lets the smallest offset win.
    always_comb begin
        pick      = last_q;
        any_ready = 1'b0;
        idx       = '0;
        for (int k = NCH; k >= 1; k--) begin
            idx = {1'b0, last_q} + (TW+1)'(k);
            if (idx >= (TW+1)'(NCH)) begin
                idx = idx - (TW+1)'(NCH);
            end
            if (bus.in_read_ready[idx[TW-1:0]]) begin
                pick      = idx[TW-1:0];
                any_ready = 1'b1;
            end
        end
    end

    // Word presented by the granted channel.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NCH; i++) begin
            if (grant_q == TW'(i)) begin
                rd_word = bus.in_out_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        last_d  = last_q;
        data_d  = data_q;
        tag_d   = tag_q;
        wv_d    = 1'b0;
        rv_c    = '0;
        case (state_q)
            IDLE: begin
                acc_d = '0;
                cnt_d = '0;
                if (any_ready) begin
                    grant_d = pick;
                    state_d = RD_REQ;
                end
            end
            RD_REQ: begin
                if (bus.in_read_ready[grant_q]) begin
                    rv_c[grant_q] = 1'b1;
                    state_d       = RD_CAP;
                end
            end
            RD_CAP: begin
                acc_d = acc_q + rd_word;
                if (cnt_q == CW'(LEN-1)) begin
                    state_d = WR_WAIT;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = RD_REQ;
                end
            end
            WR_WAIT: begin
                // The write commits here so the strobe and payload are registered.
                if (bus.out_write_ready) begin
                    wv_d    = 1'b1;
                    data_d  = acc_q;
                    tag_d   = grant_q;
                    state_d = WR;
                end
            end
            WR: begin
                last_d  = grant_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            grant_q <= '0;
            last_q  <= TW'(NCH-1);
            data_q  <= '0;
            tag_q   <= '0;
            wv_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            data_q  <= data_d;
            tag_q   <= tag_d;
            wv_q    <= wv_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    assign bus.in_read_valid   = rv_c;
    assign bus.in_rst          = '0;
    assign bus.out_in_data     = data_q;
    assign bus.out_tag         = tag_q;
    assign bus.out_write_valid = wv_q;
    assign bus.out_rst         = 1'b0;
    assign bus.busy            = busy_q;
    assign bus.grant           = grant_q;
endmodule
